packet_arbiter: RTL and testbench
=================================

# packet_arbiter

Per-output-port packet scheduler for the stream crossbar. It selects one of `NUM_REQUEST` input streams contending for a single output port and locks the grant until the packet's last beat is accepted. It applies round-robin fairness with a per-owner packet quota of `MAX_PACKETS` consecutive packets. One instance sits in front of each output mux; its one-hot grant drives the mux select and the input ready gating.

## Interface
Parameters:
- `NUM_REQUEST`, default 2: number of contending input streams.
- `MAX_PACKETS`, default 8: maximum consecutive packets one owner may send while others wait; must be ≥1.
- `TIMEOUT`, default 256: watchdog stall limit in cycles; used only when the watchdog is compiled in.
- `ID_WIDTH`, localparam, `$clog2(NUM_REQUEST)`, min 1.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  reset; synchronous, active-high.
- `request_i`  in  `NUM_REQUEST`  per-input "valid and destined to this port".
- `beat_valid_i`  in  1  output-side valid of the muxed stream.
- `beat_ready_i`  in  1  downstream ready of this output port.
- `beat_last_i`  in  1  output-side last of the muxed stream.
- `grant_o`  out  `NUM_REQUEST`  one-hot or zero, registered.
- `grant_id_o`  out  `ID_WIDTH`  binary index of the owner; 0 when idle.
- `busy_o`  out  1  high while in LOCKED.
- `timeout_o`  out  1  one-cycle pulse when the watchdog breaks a lock; constant 0 without the macro.

## Operation
- States:
  - IDLE: no owner.
  - LOCKED: owner held in `grant_o`.
- A beat completes when `beat_valid_i & beat_ready_i`. A packet ends on a completing beat with `beat_last_i`.
- IDLE with any `request_i` bit set: pick the winner by round-robin from pointer `ptr`. The first set bit at index ≥ `ptr`, wrapping to 0, wins.
  - Register the winner into `grant_o` and move to LOCKED.
  - Set `ptr = winner+1`, modulo `NUM_REQUEST`. Set `pkt_cnt = 0`.
- IDLE with no request: stay in IDLE and keep the outputs at 0.
- LOCKED: the grant is held regardless of `request_i`, so deasserting `request_i` mid-packet does not drop the lock.
- On end of packet (zero-bubble handover):
  - If the owner's `request_i` is set, `pkt_cnt < MAX_PACKETS-1`, and another request exists: keep the owner and increment `pkt_cnt`.
  - If the owner requests and no other requester is set: keep the owner, and `pkt_cnt` saturates at `MAX_PACKETS-1`.
  - Otherwise, if any other requester is set: grant the round-robin winner from `ptr`, with the old owner's bit masked, on the same edge. Update `ptr` and clear `pkt_cnt`.
  - Otherwise: go to IDLE and clear `grant_o`.
- `pkt_cnt` is `$clog2(MAX_PACKETS)` bits wide, minimum 1, and never wraps.
- Any cycle with `rst` high: state IDLE, `grant_o = 0`, `grant_id_o = 0`, `busy_o = 0`, `timeout_o = 0`, `ptr = 0`, `pkt_cnt = 0`. A packet in flight is abandoned without a last beat.

## Timing
- Latency from `request_i` rising in IDLE to `grant_o` valid is 1 cycle.
- At end of packet, the next grant is visible on the cycle after the last beat, with no idle cycle between packets.
- `grant_o`, `grant_id_o` and `busy_o` change only on a clock edge. They are stable between edges, so the muxed valid/last fed back cannot form a loop.
- `request_i` is sampled only in IDLE and on end-of-packet cycles.

## Configuration
- `PACKET_ARBITER_WATCHDOG_EN` defined:
  - A `$clog2(TIMEOUT+1)`-bit stall counter clears on every completing beat and on any state change, and increments each LOCKED cycle without a completing beat.
  - When the counter reaches `TIMEOUT`, the lock is released as on end of packet with the owner treated as not requesting. `timeout_o` pulses for 1 cycle.
- Macro undefined: no counter, `timeout_o` is tied to 0, and a lock persists indefinitely.

## Structure
- The shared package `stream_xbar_pkg` holds the state enum `arb_state_t` {IDLE, LOCKED} and a function or constant for the safe `$clog2` minimum of 1.
- Sub-module `rr_pick`: combinational, taking `request`, `ptr` and `mask` and returning a one-hot winner, an index and `any`. It is instantiated once.

## Test plan
- `NUM_REQUEST=3`, `request_i=3'b101` from reset → `grant_o=3'b001` one cycle later, with `ptr=1`. After the last beat, `grant_o=3'b100` with no gap.
- Owner drops `request_i` mid-packet with `beat_ready_i=0` → `grant_o` is held until the last beat is accepted.
- `MAX_PACKETS=2`, input 0 and input 1 both continuously requesting, single-beat packets → grant sequence 0,0,1,1,0,0.
- Sole requester input 2 sends 10 packets → grant stays `3'b100` throughout, and `pkt_cnt` saturates at 1 without wrapping.
- Assert `rst` mid-packet → next cycle all outputs are 0 and `ptr=0`. A request after reset is re-granted from index 0.
- Macro on, `TIMEOUT=4`, owner valid with `beat_ready_i=0` for 4 cycles → `timeout_o` pulses and the grant moves to the next requester or to IDLE.

Source files
------------

// File: rtl/stream_xbar_pkg.sv
// Shared types and helpers for the stream crossbar: arbiter state enum and a
// $clog2 variant that never returns less than 1.
package stream_xbar_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/packet_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible (request & ~mask) bit at
// index >= ptr, wrapping to 0. Returns one-hot, binary index and any.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] request,
  input  logic [W-1:0] ptr,
  input  logic [N-1:0] mask,
  output logic [N-1:0] grant,
  output logic [W-1:0] index,
  output logic         any
);

  logic [N-1:0] eligible;

  assign eligible = request & ~mask;

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    index = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && eligible[j[W-1:0]]) begin
        any               = 1'b1;
        grant[j[W-1:0]]   = 1'b1;
        index             = j[W-1:0];
      end
    end
  end

endmodule

// File: rtl/packet_arbiter.sv
// Per-output-port packet arbiter: round-robin with a per-owner packet quota and
// grant locked until the last beat. Optional watchdog: PACKET_ARBITER_WATCHDOG_EN.
module packet_arbiter
  import stream_xbar_pkg::*;
#(
  parameter  int NUM_REQUEST = 2,
  parameter  int MAX_PACKETS = 8,
  parameter  int TIMEOUT     = 256,
  localparam int ID_WIDTH    = clog2_min1(NUM_REQUEST)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQUEST-1:0] request_i,
  input  logic                   beat_valid_i,
  input  logic                   beat_ready_i,
  input  logic                   beat_last_i,
  output logic [NUM_REQUEST-1:0] grant_o,
  output logic [ID_WIDTH-1:0]    grant_id_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int CNT_W = clog2_min1(MAX_PACKETS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PACKETS - 1);

  // Handshake: a beat completes on beat_valid_i & beat_ready_i; only a
  // completing beat with beat_last_i ends a packet and may move the grant.
  arb_state_t             state, state_next;
  logic [NUM_REQUEST-1:0] grant_next;
  logic [ID_WIDTH-1:0]    id_next;
  logic [ID_WIDTH-1:0]    ptr, ptr_next, ptr_after_pick;
  logic [CNT_W-1:0]       pkt_cnt, cnt_next;
  logic [NUM_REQUEST-1:0] pick_mask, pick_grant;
  logic [ID_WIDTH-1:0]    pick_index;
  logic                   pick_any;
  logic                   beat_done, eop, owner_req, keep, wd_release;

  assign beat_done = beat_valid_i & beat_ready_i;
  assign eop       = (state == LOCKED) & beat_done & beat_last_i;
  assign owner_req = |(request_i & grant_o);
  assign keep      = eop & owner_req;
  assign busy_o    = (state == LOCKED);

  // In LOCKED the current owner is masked so pick_any means "another requester".
  assign pick_mask = (state == LOCKED) ? grant_o : '0;
  assign ptr_after_pick = (pick_index == ID_WIDTH'(NUM_REQUEST - 1)) ? '0
                                                                     : pick_index + 1'b1;

  rr_pick #(
    .N (NUM_REQUEST),
    .W (ID_WIDTH)
  ) u_rr_pick (
    .request (request_i),
    .ptr     (ptr),
    .mask    (pick_mask),
    .grant   (pick_grant),
    .index   (pick_index),
    .any     (pick_any)
  );

`ifdef PACKET_ARBITER_WATCHDOG_EN
  localparam int STALL_W = clog2_min1(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_cnt;

  // Release on the stalled cycle that would bring the counter to TIMEOUT.
  assign wd_release = (state == LOCKED) & ~beat_done &
                      (stall_cnt == STALL_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= wd_release;
      if (beat_done || wd_release || (state_next != state))
        stall_cnt <= '0;
      else if (state == LOCKED)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_release     = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  always_comb begin
    state_next = state;
    grant_next = grant_o;
    id_next    = grant_id_o;
    ptr_next   = ptr;
    cnt_next   = pkt_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_next = LOCKED;
          grant_next = pick_grant;
          id_next    = pick_index;
          ptr_next   = ptr_after_pick;
          cnt_next   = '0;
        end
      end
      LOCKED: begin
        if (eop || wd_release) begin
          if (keep && (!pick_any || pkt_cnt < CNT_MAX)) begin
            if (pkt_cnt < CNT_MAX) cnt_next = pkt_cnt + 1'b1;
          end else if (pick_any) begin
            grant_next = pick_grant;
            id_next    = pick_index;
            ptr_next   = ptr_after_pick;
            cnt_next   = '0;
          end else begin
            state_next = IDLE;
            grant_next = '0;
            id_next    = '0;
            cnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        id_next    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_o    <= '0;
      grant_id_o <= '0;
      ptr        <= '0;
      pkt_cnt    <= '0;
    end else begin
      state      <= state_next;
      grant_o    <= grant_next;
      grant_id_o <= id_next;
      ptr        <= ptr_next;
      pkt_cnt    <= cnt_next;
    end
  end

endmodule

// File: tb/tb_packet_arbiter.sv
// Self-checking bench for packet_arbiter (NUM_REQUEST=3, MAX_PACKETS=2,
// TIMEOUT=4): directed scenarios plus random traffic against an owner-level model.
module tb_packet_arbiter;

  localparam int N   = 3;
  localparam int MAX = 2;
  localparam int TO  = 4;
  localparam int W   = 7;
`ifdef PACKET_ARBITER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] request;
  logic         beat_valid, beat_ready, beat_last;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         busy, timeout;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  int m_owner, m_ptr, m_cnt, m_stall;
  bit m_to;

  packet_arbiter #(
    .NUM_REQUEST (N),
    .MAX_PACKETS (MAX),
    .TIMEOUT     (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .request_i    (request),
    .beat_valid_i (beat_valid),
    .beat_ready_i (beat_ready),
    .beat_last_i  (beat_last),
    .grant_o      (grant),
    .grant_id_o   (grant_id),
    .busy_o       (busy),
    .timeout_o    (timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] bits, input int p);
    for (int i = 0; i < N; i++)
      if (bits[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Owner-level reference: who holds the port, the round-robin start and quota.
  task automatic model_edge();
    int w;
    logic [N-1:0] others;
    bit done, eop, timed, own;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_stall = 0; m_to = 0;
      return;
    end
    m_to = 0;
    done = beat_valid && beat_ready;
    if (m_owner < 0) begin
      w = pick(request, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_ptr = (w + 1) % N; m_cnt = 0; m_stall = 0;
      end
    end else begin
      eop   = done && beat_last;
      timed = WD && !done && (m_stall == TO - 1);
      if (eop || timed) begin
        own    = eop && request[m_owner];
        others = request & ~(N'(1) << m_owner);
        if (own && (others == 0 || m_cnt < MAX - 1)) begin
          if (m_cnt < MAX - 1) m_cnt++;
        end else if (others != 0) begin
          w = pick(others, m_ptr);
          m_owner = w; m_ptr = (w + 1) % N; m_cnt = 0;
        end else begin
          m_owner = -1; m_cnt = 0;
        end
        m_to = timed;
        m_stall = 0;
      end else begin
        m_stall = done ? 0 : m_stall + 1;
      end
    end
  endtask

  function automatic logic [W-1:0] model_pack();
    logic [N-1:0] g;
    logic [1:0]   id;
    g  = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    id = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    return {m_to, (m_owner >= 0), id, g};
  endfunction

  // One clock: model follows the edge, scoreboard compares at the falling edge.
  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_pack());
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("grant",    grant,    e[2:0]);
    check_eq("grant_id", grant_id, e[4:3]);
    check_eq("busy",     busy,     e[5]);
    check_eq("timeout",  timeout,  e[6]);
  endtask

  // driver
  task automatic drive(input logic [N-1:0] req, input logic v, input logic r, input logic l);
    request = req; beat_valid = v; beat_ready = r; beat_last = l;
  endtask

  initial begin
    logic [N-1:0] seq_exp[6];
    seq_exp[0] = 3'b001; seq_exp[1] = 3'b001; seq_exp[2] = 3'b010;
    seq_exp[3] = 3'b010; seq_exp[4] = 3'b001; seq_exp[5] = 3'b001;

    rst = 1'b1;
    drive('0, 0, 0, 0);
    step(); step();
    check_eq("reset_grant", grant, 0);
    check_eq("reset_ptr", dut.ptr, 0);
    rst = 1'b0;

    // 101 from reset: input 0 wins, then input 2 with no gap
    drive(3'b101, 0, 0, 0);
    step();
    check_eq("first_grant", grant, 3'b001);
    check_eq("first_ptr", dut.ptr, 1);
    drive(3'b100, 1, 1, 1);
    step();
    check_eq("handover_grant", grant, 3'b100);

    // owner drops request mid-packet while stalled
    drive(3'b000, 1, 0, 1);
    for (int i = 0; i < 3; i++) step();
    check_eq("hold_grant", grant, 3'b100);
    drive(3'b000, 1, 1, 1);
    step();
    check_eq("release_idle", grant, 3'b000);

    // quota of two packets: 0,0,1,1,0,0
    drive(3'b011, 1, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("quota_seq%0d", i), grant, seq_exp[i]);
    end
    drive(3'b000, 1, 1, 1);
    step();

    // sole requester, ten packets, counter saturates
    drive(3'b100, 1, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("sole_grant", grant, 3'b100);
    end
    check_eq("sole_pkt_cnt", dut.pkt_cnt, 1);

    // reset mid-packet, then re-grant from index 0
    drive(3'b011, 1, 0, 0);
    step();
    rst = 1'b1;
    step();
    check_eq("midrst_grant", grant, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_ptr", dut.ptr, 0);
    rst = 1'b0;
    drive(3'b110, 0, 0, 0);
    step();
    check_eq("regrant", grant, 3'b010);

    // stall with owner valid and downstream not ready
    drive(3'b101, 1, 0, 0);
    for (int i = 0; i < 4; i++) step();
`ifdef PACKET_ARBITER_WATCHDOG_EN
    check_eq("wd_pulse", timeout, 1);
    check_eq("wd_grant", grant, 3'b100);
    step();
    check_eq("wd_pulse_end", timeout, 0);
`else
    check_eq("no_wd_pulse", timeout, 0);
    check_eq("no_wd_grant", grant, 3'b010);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(N'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
